// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester, consumer and status signals of the two-way operand bus arbiter.
interface bus_arbiter_if #(parameter int DATA_WIDTH = 8);
  logic                  req0, ack0, req1, ack1;
  logic [DATA_WIDTH-1:0] data0, data1, bus_data;
  logic                  select, bus_valid, bus_ready, busy;
  modport master (output req0, data0, req1, data1, bus_ready,
                  input  ack0, ack1, select, bus_data, bus_valid, busy);
  modport slave  (input  req0, data0, req1, data1, bus_ready,
                  output ack0, ack1, select, bus_data, bus_valid, busy);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin, burst-bounded arbiter of two requesters onto one registered valid/ready bus.
module bus_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t                state, nxt, other;
  logic [3:0]            beat;
  logic                  last, accept, ack, own_req, oth_req, burst_end;
  logic [DATA_WIDTH-1:0] word;
  assign accept    = !bus.bus_valid || bus.bus_ready;
  assign bus.ack0  = state == OWN0 && bus.req0 && accept;
  assign bus.ack1  = state == OWN1 && bus.req1 && accept;
  assign ack       = bus.ack0 || bus.ack1;
  assign word      = bus.ack1 ? bus.data1 : bus.data0;
  assign bus.select = state == OWN1;
  assign bus.busy   = state != IDLE;
  always_comb begin
    other     = state == OWN0 ? OWN1 : OWN0;
    own_req   = state == OWN1 ? bus.req1 : bus.req0;
    oth_req   = state == OWN1 ? bus.req0 : bus.req1;
    burst_end = ack && beat == 4'(BURST_LEN - 1);
    nxt       = state;
    if (state == IDLE)
      nxt = (bus.req0 && bus.req1) ? (last ? OWN0 : OWN1) :
            bus.req0 ? OWN0 : bus.req1 ? OWN1 : IDLE;
    else if (burst_end)
      nxt = oth_req ? other : state;
    else if (!own_req)
      nxt = oth_req ? other : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      beat          <= '0;
      bus.bus_data  <= '0;
      bus.bus_valid <= 1'b0;
    end else begin
      state <= nxt;
      // any grant (fresh or handover) restarts the burst count and records the owner
      if (nxt != state && nxt != IDLE) begin
        last <= nxt == OWN1;
        beat <= '0;
      end else if (burst_end)
        beat <= '0;
      else if (ack)
        beat <= beat + 4'd1;
      if (ack) begin
        bus.bus_data  <= word;
        bus.bus_valid <= 1'b1;
      end else if (bus.bus_ready)
        bus.bus_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized stimulus against an ownership/turn-count reference model.
module tb_bus_arbiter;
  localparam int DW = 8;
  localparam int BL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bus_arbiter_if #(.DATA_WIDTH(DW)) intf ();
  bus_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (.clk(clk), .rst_n(rst_n), .bus(intf));
  int n_vec = 0;
  int n_err = 0;
  logic          r0, r1, rdy, a0, a1, mv;
  logic [DW-1:0] d0, d1, md;
  int            owner, beats, last;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    owner = -1; beats = 0; last = 1; mv = 1'b0; md = '0; a0 = 1'b0; a1 = 1'b0;
  endfunction
  function automatic void grant(int i);
    owner = i; last = i; beats = 0;
  endfunction
  // one clock edge of the reference: output stage first, then ownership bookkeeping
  function automatic void model_edge();
    logic [1:0] rq;
    rq = {r1, r0};
    if (a0 || a1) begin
      md = a0 ? d0 : d1;
      mv = 1'b1;
    end else if (mv && rdy) mv = 1'b0;
    if (owner < 0) begin
      if (rq == 2'b11) grant(1 - last);
      else if (rq[0]) grant(0);
      else if (rq[1]) grant(1);
    end else if (a0 || a1) begin
      beats++;
      if (beats == BL) begin
        if (rq[1 - owner]) grant(1 - owner);
        else beats = 0;
      end
    end else if (!rq[owner]) begin
      if (rq[1 - owner]) grant(1 - owner);
      else owner = -1;
    end
  endfunction
  task automatic step();
    intf.req0 = r0; intf.req1 = r1; intf.data0 = d0; intf.data1 = d1; intf.bus_ready = rdy;
    #1;
    a0 = owner == 0 && r0 && (!mv || rdy);
    a1 = owner == 1 && r1 && (!mv || rdy);
    chk("ack0", intf.ack0, a0);
    chk("ack1", intf.ack1, a1);
    chk("ack_excl", intf.ack0 & intf.ack1, 0);
    chk("select", intf.select, owner == 1);
    chk("busy", intf.busy, owner >= 0);
    chk("bus_valid", intf.bus_valid, mv);
    chk("bus_data", intf.bus_data, md);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic next_data();
    if (!r0 || a0) d0 = DW'($urandom);
    if (!r1 || a1) d1 = DW'($urandom);
  endtask
  // asserted a few ns into the low phase so the check lands before the next rising edge
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", intf.bus_valid, 0);
    chk("rst_data", intf.bus_data, 0);
    chk("rst_select", intf.select, 0);
    chk("rst_busy", intf.busy, 0);
    chk("rst_acks", {intf.ack1, intf.ack0}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    r0 = 1'b0; r1 = 1'b0; rdy = 1'b1; d0 = '0; d1 = '0;
    intf.req0 = 1'b0; intf.req1 = 1'b0; intf.data0 = '0; intf.data1 = '0; intf.bus_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    r0 = 1'b1; d0 = 8'hA5;
    step(); step();
    r0 = 1'b0;
    step();
    chk("single_a5", intf.bus_data, 8'hA5);
    step();
    async_reset();
    r0 = 1'b1; r1 = 1'b1;
    repeat (24) begin step(); next_data(); end
    r0 = 1'b0; r1 = 1'b0;
    step(); step();
    async_reset();
    r1 = 1'b1; d1 = 8'h3C;
    step(); step();
    d1 = 8'h77; rdy = 1'b0;
    repeat (3) step();
    chk("bp_hold", intf.bus_data, 8'h3C);
    rdy = 1'b1;
    step(); step();
    r1 = 1'b0;
    repeat (3) step();
    async_reset();
    r0 = 1'b1;
    repeat (3) begin step(); next_data(); end
    r0 = 1'b0; r1 = 1'b1;
    step(); step();
    r1 = 1'b0;
    repeat (3) step();
    async_reset();
    r0 = 1'b1; d0 = 8'h00;
    step();
    repeat (10) begin step(); if (a0) d0 = d0 + 8'd1; end
    r0 = 1'b0;
    step();
    chk("burst_last", intf.bus_data, 8'h09);
    step();
    async_reset();
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
      next_data();
      r0  = $urandom_range(0, 3) != 0;
      r1  = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 3) != 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
